// File: rtl/switch_select_encoder_pkg.sv
// Constants shared by the switch-select encoder, the LED demux top and the
// count_and_toggle users, plus the press-to-code priority encoder.
package switch_select_encoder_pkg;

  localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;  // 10 ms at 25 MHz
  localparam int SEL_W  = 2;
  localparam int NUM_SW = 4;

  // Lowest-numbered rising switch wins; the others in the same cycle are dropped.
  function automatic logic [SEL_W-1:0] prio_encode(input logic [NUM_SW-1:0] rise);
    logic [SEL_W-1:0] code;
    code = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (rise[i]) code = SEL_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/switch_select_encoder_debounce_filter.sv
// Per-switch 2-flop synchroniser followed by a consecutive-cycle debounce
// counter; the stable output flips only after DEBOUNCE_LIMIT disagreeing cycles.
module debounce_filter
  import switch_select_encoder_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any cycle agreeing with the stable state forfeits the whole count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= i_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_stable = stable_q;

endmodule

// File: rtl/switch_select_encoder.sv
// Turns four raw push buttons into the registered 2-bit select code of the
// most recently pressed button, with a per-press valid pulse and a held flag.
module switch_select_encoder
  import switch_select_encoder_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_switch_1,
  input  logic i_switch_2,
  input  logic i_switch_3,
  input  logic i_switch_4,
  output logic o_sel0,
  output logic o_sel1,
  output logic o_valid,
  output logic o_any
);

  logic [NUM_SW-1:0] raw;
  logic [NUM_SW-1:0] stable;
  logic [NUM_SW-1:0] stable_d_q;
  logic [NUM_SW-1:0] rise;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;
  logic              valid_q;
  logic              valid_d;
  logic              any_q;
  logic              any_d;

  assign raw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

  for (genvar k = 0; k < NUM_SW; k++) begin : g_db
    debounce_filter #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_db (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (raw[k]),
      .o_stable(stable[k])
    );
  end

  // Only presses select; releases and held combinations leave the code alone.
  assign rise = stable & ~stable_d_q;

  always_comb begin
    sel_d   = sel_q;
    valid_d = |rise;
    any_d   = |stable;
    if (|rise) sel_d = prio_encode(rise);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_d_q <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      any_q      <= 1'b0;
    end else begin
      stable_d_q <= stable;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      any_q      <= any_d;
    end
  end

  assign o_sel0  = sel_q[0];
  assign o_sel1  = sel_q[1];
  assign o_valid = valid_q;
  assign o_any   = any_q;

endmodule

// File: tb/tb_switch_select_encoder.sv
// Directed bench for switch_select_encoder with DEBOUNCE_LIMIT=4: a windowed
// press model checked every cycle plus literal per-scenario expectations.
module tb_switch_select_encoder;

  localparam int DL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
  logic o_sel0, o_sel1, o_valid, o_any;

  int errors = 0;
  int checks = 0;

  // Model state: debounced levels, previous-cycle levels, expected outputs and
  // the last DL+1 raw samples (index 0 oldest).
  logic [3:0] m_stable = '0;
  logic [3:0] m_stable_prev = '0;
  logic [1:0] exp_sel = '0;
  logic       exp_valid = 1'b0;
  logic       exp_any = 1'b0;
  logic [3:0] win_q[$];

  switch_select_encoder #(.DEBOUNCE_LIMIT(DL)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_switch_1(sw1),
    .i_switch_2(sw2),
    .i_switch_3(sw3),
    .i_switch_4(sw4),
    .o_sel0    (o_sel0),
    .o_sel1    (o_sel1),
    .o_valid   (o_valid),
    .o_any     (o_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a switch's level changes once the synchronised input (raw delayed
  // two samples) has disagreed with it for DL consecutive cycles; the outputs
  // report the rise one cycle later.
  always @(posedge clk) begin
    logic [3:0] raw_now;
    logic [3:0] rise;
    logic [3:0] nxt;
    logic       found;
    logic       all_diff;
    raw_now = {sw4, sw3, sw2, sw1};
    if (!rst_n) begin
      m_stable      = '0;
      m_stable_prev = '0;
      exp_sel       = '0;
      exp_valid     = 1'b0;
      exp_any       = 1'b0;
      win_q.delete();
      for (int j = 0; j <= DL; j++) win_q.push_back(4'b0000);
    end else begin
      rise      = m_stable & ~m_stable_prev;
      exp_valid = (rise != 4'b0000);
      exp_any   = (m_stable != 4'b0000);
      found     = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (rise[k] && !found) begin
          exp_sel = 2'(k);
          found   = 1'b1;
        end
      end
      nxt = m_stable;
      for (int k = 0; k < 4; k++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DL; j++) begin
          if (win_q[j][k] == m_stable[k]) all_diff = 1'b0;
        end
        if (all_diff) nxt[k] = ~m_stable[k];
      end
      m_stable_prev = m_stable;
      m_stable      = nxt;
      void'(win_q.pop_front());
      win_q.push_back(raw_now);
    end
    #2;
    check("model_sel", {30'd0, o_sel1, o_sel0}, {30'd0, exp_sel});
    check("model_valid", {31'd0, o_valid}, {31'd0, exp_valid});
    check("model_any", {31'd0, o_any}, {31'd0, exp_any});
  end

  task automatic set_sw(input logic [3:0] v);
    @(negedge clk);
    {sw4, sw3, sw2, sw1} = v;
  endtask

  // Runs n clock edges and summarises what the outputs did (indices from 1,
  // 0 meaning never).
  task automatic run_edges(input int n, output int nvalid, output int first_valid,
                           output int first_any_hi, output int first_any_lo,
                           output logic [1:0] sel_last);
    nvalid = 0; first_valid = 0; first_any_hi = 0; first_any_lo = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #3;
      if (o_valid) begin
        nvalid++;
        if (first_valid == 0) first_valid = i;
      end
      if (o_any && first_any_hi == 0) first_any_hi = i;
      if (!o_any && first_any_lo == 0) first_any_lo = i;
    end
    sel_last = {o_sel1, o_sel0};
  endtask

  initial begin
    int nv, fv, fh, fl, tot;
    logic [1:0] sl;
    logic [7:0] pat;

    // Reset with switches toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {sw4, sw3, sw2, sw1} = (i % 2 == 0) ? 4'b1111 : 4'b0101;
      @(posedge clk);
      #3;
      check("rst_outputs", {28'd0, o_sel1, o_sel0, o_valid, o_any}, 32'd0);
    end
    @(negedge clk);
    {sw4, sw3, sw2, sw1} = 4'b0000;
    rst_n = 1'b1;
    run_edges(7, nv, fv, fh, fl, sl);
    check("post_rst_valid", nv, 0);
    check("post_rst_any", fh, 0);
    check("post_rst_sel", sl, 2'b00);

    // Clean press and release of switch 3.
    set_sw(4'b0100);
    run_edges(12, nv, fv, fh, fl, sl);
    check("sw3_valid_cycle", fv, 7);
    check("sw3_valid_count", nv, 1);
    check("sw3_any_cycle", fh, 7);
    check("sw3_sel", sl, 2'b10);
    set_sw(4'b0000);
    run_edges(12, nv, fv, fh, fl, sl);
    check("sw3_rel_any_cycle", fl, 7);
    check("sw3_rel_valid", nv, 0);
    check("sw3_rel_sel", sl, 2'b10);

    // Bouncing switch 2, then held.
    pat = 8'b1110_1110;
    tot = 0;
    for (int j = 0; j < 8; j++) begin
      set_sw({2'b00, pat[7-j], 1'b0});
      run_edges(1, nv, fv, fh, fl, sl);
      tot += nv;
    end
    check("bounce_no_early_valid", tot, 0);
    set_sw(4'b0010);
    run_edges(14, nv, fv, fh, fl, sl);
    check("bounce_valid_cycle", fv, 7);
    check("bounce_valid_total", tot + nv, 1);
    check("bounce_sel", sl, 2'b01);
    set_sw(4'b0000);
    run_edges(10, nv, fv, fh, fl, sl);

    // Simultaneous press of switches 2 and 4.
    set_sw(4'b1010);
    run_edges(12, nv, fv, fh, fl, sl);
    check("simul_valid_count", nv, 1);
    check("simul_sel", sl, 2'b01);
    set_sw(4'b1000);
    run_edges(10, nv, fv, fh, fl, sl);
    check("simul_rel2_valid", nv, 0);
    check("simul_rel2_sel", sl, 2'b01);
    set_sw(4'b1010);
    run_edges(10, nv, fv, fh, fl, sl);
    check("simul_repress2_count", nv, 1);
    check("simul_repress2_sel", sl, 2'b01);
    set_sw(4'b0000);
    run_edges(10, nv, fv, fh, fl, sl);
    set_sw(4'b1000);
    run_edges(10, nv, fv, fh, fl, sl);
    check("sw4_alone_cycle", fv, 7);
    check("sw4_alone_sel", sl, 2'b11);

    // Reset during debounce of switch 1.
    set_sw(4'b0000);
    run_edges(10, nv, fv, fh, fl, sl);
    set_sw(4'b0001);
    run_edges(4, nv, fv, fh, fl, sl);
    check("middeb_no_valid", nv, 0);
    @(negedge clk);
    rst_n = 1'b0;
    run_edges(2, nv, fv, fh, fl, sl);
    check("middeb_rst_sel", sl, 2'b00);
    check("middeb_rst_valid", nv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_edges(10, nv, fv, fh, fl, sl);
    check("middeb_valid_cycle", fv, 7);
    check("middeb_valid_count", nv, 1);
    check("middeb_any_cycle", fh, 7);
    check("middeb_sel", sl, 2'b00);

    // Press, release, press switch 4.
    set_sw(4'b0000);
    run_edges(10, nv, fv, fh, fl, sl);
    set_sw(4'b1000);
    run_edges(9, nv, fv, fh, fl, sl);
    tot = nv;
    check("repress_first_cycle", fv, 7);
    set_sw(4'b0000);
    run_edges(9, nv, fv, fh, fl, sl);
    check("repress_release_valid", nv, 0);
    set_sw(4'b1000);
    run_edges(12, nv, fv, fh, fl, sl);
    check("repress_second_cycle", fv, 7);
    check("repress_total", tot + nv, 2);
    check("repress_sel", sl, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
